m003_serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full adder. It accepts WIDTH-bit operands on a start strobe and processes them DIGIT bits per clock through a carry register. It presents the registered sum/carry with a one-cycle done pulse. It serves as the area-lean arithmetic primitive for wide datapaths in the module series.

---
 rtl/m003_serial_adder_pkg.sv | 7 +
 rtl/m003_serial_adder_if.sv | 15 +
 rtl/m003_digit_adder.sv | 23 ++
 rtl/m003_serial_adder.sv | 89 ++++++++
 tb/tb_m003_serial_adder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/m003_serial_adder_pkg.sv
// m003_serial_adder_pkg: FSM state type and step-counter sizing for the serial adder
package m003_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic int cnt_w(input int width, input int digit);
    return (width / digit) > 1 ? $clog2(width / digit) : 1;
  endfunction
endpackage

// File: rtl/m003_serial_adder_if.sv
// m003_serial_adder_if: operand/result bundle of the serial adder
// master drives start_i/a_i/b_i/cin_i/sub_i and observes busy_o/done_o/sum_o/cout_o;
// slave is the adder side; ovf_o exists only with M003_SERIAL_ADDER_OVF_EN
interface m003_serial_adder_if #(parameter int WIDTH = 32);
  logic start_i, cin_i, sub_i, busy_o, done_o, cout_o;
  logic [WIDTH-1:0] a_i, b_i, sum_o;
`ifdef M003_SERIAL_ADDER_OVF_EN
  logic ovf_o;
  modport master(output start_i, a_i, b_i, cin_i, sub_i, input busy_o, done_o, sum_o, cout_o, ovf_o);
  modport slave(input start_i, a_i, b_i, cin_i, sub_i, output busy_o, done_o, sum_o, cout_o, ovf_o);
`else
  modport master(output start_i, a_i, b_i, cin_i, sub_i, input busy_o, done_o, sum_o, cout_o);
  modport slave(input start_i, a_i, b_i, cin_i, sub_i, output busy_o, done_o, sum_o, cout_o);
`endif
endinterface

// File: rtl/m003_digit_adder.sv
// m003_digit_adder: DIGIT-bit combinational ripple of full adders
// a/b/cin in, sum/cout out; msb_cin (carry into the top bit) only with M003_SERIAL_ADDER_OVF_EN
module m003_digit_adder #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
`ifdef M003_SERIAL_ADDER_OVF_EN
  output logic             msb_cin,
`endif
  output logic             cout
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[DIGIT];
`ifdef M003_SERIAL_ADDER_OVF_EN
  assign msb_cin = c[DIGIT-1];
`endif
endmodule

// File: rtl/m003_serial_adder.sv
// m003_serial_adder: multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock
// clk_i/rst_i (async, active-high) plus the slave side of m003_serial_adder_if;
// M003_SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf_o
module m003_serial_adder
  import m003_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic clk_i,
  input logic rst_i,
  m003_serial_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic c_q, cout_q, done_q;
  logic [DIGIT-1:0] dsum;
  logic dcout;
`ifdef M003_SERIAL_ADDER_OVF_EN
  logic dmsb, m_q, ovf_q;
`endif
  m003_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a(a_q[DIGIT-1:0]),
    .b(b_q[DIGIT-1:0]),
    .cin(c_q),
    .sum(dsum),
`ifdef M003_SERIAL_ADDER_OVF_EN
    .msb_cin(dmsb),
`endif
    .cout(dcout)
  );
  always_comb begin
    state_d = state_q == IDLE ? (bus.start_i ? BUSY : IDLE)
            : state_q == BUSY ? (cnt_q == LAST ? DONE : BUSY)
            : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef M003_SERIAL_ADDER_OVF_EN
      m_q     <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DONE;
      if (state_q == IDLE && bus.start_i) begin
        a_q   <= bus.a_i;
        b_q   <= bus.sub_i ? ~bus.b_i : bus.b_i;
        c_q   <= bus.sub_i | bus.cin_i;
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        c_q   <= dcout;
        acc_q <= WIDTH'({dsum, acc_q} >> DIGIT);
        cnt_q <= cnt_q + 1'b1;
`ifdef M003_SERIAL_ADDER_OVF_EN
        m_q   <= dmsb;
`endif
      end else if (state_q == DONE) begin
        sum_q  <= acc_q;
        cout_q <= c_q;
`ifdef M003_SERIAL_ADDER_OVF_EN
        ovf_q  <= m_q ^ c_q;
`endif
      end
    end
  end
  assign bus.busy_o = state_q == BUSY;
  assign bus.done_o = done_q;
  assign bus.sum_o  = sum_q;
  assign bus.cout_o = cout_q;
`ifdef M003_SERIAL_ADDER_OVF_EN
  assign bus.ovf_o  = ovf_q;
`endif
endmodule

// File: tb/tb_m003_serial_adder.sv
// tb_m003_serial_adder: scoreboard bench for three serial-adder configurations
module tb_m003_serial_adder;
  typedef struct {
    logic [7:0] sum;
    logic cout;
    logic ovf;
    int tag;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  int cyc = 0, checks = 0, failures = 0;
  int busy_n[3], done_n[3];
  exp_t q0[$], q1[$], q2[$];
  m003_serial_adder_if #(.WIDTH(8)) b8();
  m003_serial_adder_if #(.WIDTH(4)) b41();
  m003_serial_adder_if #(.WIDTH(4)) b44();
  m003_serial_adder #(.WIDTH(8), .DIGIT(2)) u8 (.clk_i(clk), .rst_i(rst), .bus(b8));
  m003_serial_adder #(.WIDTH(4), .DIGIT(1)) u41 (.clk_i(clk), .rst_i(rst), .bus(b41));
  m003_serial_adder #(.WIDTH(4), .DIGIT(4)) u44 (.clk_i(clk), .rst_i(rst), .bus(b44));
`ifdef M003_SERIAL_ADDER_OVF_EN
  wire o8 = b8.ovf_o, o41 = b41.ovf_o, o44 = b44.ovf_o;
`else
  wire o8 = 1'b0, o41 = 1'b0, o44 = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic cin, logic sub, int tag);
    logic [8:0] mask, bb, f;
    exp_t e;
    mask = 9'((1 << w) - 1);
    bb = {1'b0, sub ? ~b : b} & mask;
    f = ({1'b0, a} & mask) + bb + {8'd0, sub | cin};
    e.sum = f[7:0] & mask[7:0];
    e.cout = f[w];
    e.ovf = (a[w-1] == bb[w-1]) && (f[w-1] != a[w-1]);
    e.tag = tag;
    return e;
  endfunction
  task automatic mon(int i, int steps, logic done, logic busy, logic [7:0] sum, logic cout, logic ovf);
    exp_t e;
    int sz;
    if (rst) begin
      busy_n[i] = 0;
      return;
    end
    if (busy) busy_n[i]++;
    if (!done) return;
    done_n[i]++;
    sz = i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
    chk($sformatf("expected_pending%0d", i), 32'(sz != 0), 1);
    if (sz == 0) return;
    if (i == 0) e = q0.pop_front();
    else if (i == 1) e = q1.pop_front();
    else e = q2.pop_front();
    chk($sformatf("sum%0d", i), 32'(sum), 32'(e.sum));
    chk($sformatf("cout%0d", i), 32'(cout), 32'(e.cout));
`ifdef M003_SERIAL_ADDER_OVF_EN
    chk($sformatf("ovf%0d", i), 32'(ovf), 32'(e.ovf));
`else
    if (ovf) $display("note: ovf tied low");
`endif
    chk($sformatf("latency%0d", i), 32'(cyc - e.tag - 1), 32'(steps + 1));
    chk($sformatf("busy_cycles%0d", i), 32'(busy_n[i]), 32'(steps));
    busy_n[i] = 0;
  endtask
  always @(negedge clk) mon(0, 4, b8.done_o, b8.busy_o, b8.sum_o, b8.cout_o, o8);
  always @(negedge clk) mon(1, 4, b41.done_o, b41.busy_o, 8'(b41.sum_o), b41.cout_o, o41);
  always @(negedge clk) mon(2, 1, b44.done_o, b44.busy_o, 8'(b44.sum_o), b44.cout_o, o44);
  task automatic go(logic [2:0] m, logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    @(negedge clk);
    b8.a_i = a;
    b8.b_i = b;
    b41.a_i = a[3:0];
    b41.b_i = b[3:0];
    b44.a_i = a[3:0];
    b44.b_i = b[3:0];
    {b8.cin_i, b41.cin_i, b44.cin_i} = {3{cin}};
    {b8.sub_i, b41.sub_i, b44.sub_i} = {3{sub}};
    {b44.start_i, b41.start_i, b8.start_i} = m;
    if (m[0]) q0.push_back(model(8, a, b, cin, sub, cyc));
    if (m[1]) q1.push_back(model(4, a, b, cin, sub, cyc));
    if (m[2]) q2.push_back(model(4, a, b, cin, sub, cyc));
    @(negedge clk);
    {b44.start_i, b41.start_i, b8.start_i} = 3'b000;
  endtask
  task automatic drain(int budget);
    int n = 0;
    while (q0.size() + q1.size() + q2.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 1);
  endtask
  initial begin
    int n0;
    {b8.start_i, b41.start_i, b44.start_i} = 3'b000;
    {b8.cin_i, b41.cin_i, b44.cin_i, b8.sub_i, b41.sub_i, b44.sub_i} = '0;
    b8.a_i = '0; b8.b_i = '0; b41.a_i = '0; b41.b_i = '0; b44.a_i = '0; b44.b_i = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy8", 32'(b8.busy_o), 0);
    chk("rst_done8", 32'(b8.done_o), 0);
    chk("rst_sum8", 32'(b8.sum_o), 0);
    chk("rst_cout8", 32'(b8.cout_o), 0);
    chk("rst_sum41", 32'(b41.sum_o), 0);
    chk("rst_sum44", 32'(b44.sum_o), 0);
`ifdef M003_SERIAL_ADDER_OVF_EN
    chk("rst_ovf8", 32'(o8), 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_done", 32'(b8.done_o | b41.done_o | b44.done_o), 0);
    end
    go(3'b001, 8'h5A, 8'h33, 1'b0, 1'b0);
    drain(20);
    go(3'b001, 8'hFF, 8'h00, 1'b1, 1'b0);
    drain(20);
    go(3'b001, 8'h10, 8'h20, 1'b0, 1'b1);
    drain(20);
    repeat (6) begin
      go(3'b001, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      drain(20);
    end
    n0 = done_n[0];
    go(3'b001, 8'h81, 8'h7E, 1'b0, 1'b0);
    b8.a_i = 8'h11;
    b8.b_i = 8'h22;
    b8.start_i = 1'b1;
    @(negedge clk);
    b8.start_i = 1'b0;
    drain(20);
    repeat (10) @(negedge clk);
    chk("single_done", 32'(done_n[0] - n0), 1);
    go(3'b001, 8'h3C, 8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sum8", 32'(b8.sum_o), 0);
    chk("midrst_busy8", 32'(b8.busy_o), 0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(b8.done_o), 0);
    end
    go(3'b001, 8'h3C, 8'h0F, 1'b1, 1'b0);
    drain(20);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 4; s++) begin
          go(3'b110, 8'(a), 8'(b), s[0], s[1]);
          drain(20);
        end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
